// File: rtl/lif_pkg.sv
// Shared definitions for the leaky integrate-and-fire neuron datapaths.
package lif_pkg;

    // Layer sequencer states.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Post-fire membrane handling.
    localparam logic RST_ZERO = 1'b0;
    localparam logic RST_SUB  = 1'b1;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lif_update.sv
// Single-neuron membrane update: leak, integrate, saturate, threshold, reset.
// Purely combinational so it can sit behind either a serial layer
// sequencer or a standalone one-neuron tile.
module lif_update
    import lif_pkg::*;
#(
    parameter int U_BITS = 8,
    parameter int SUM_W  = 4
) (
    input  logic [U_BITS-1:0] i_u,
    input  logic [SUM_W-1:0]  i_sum,
    input  logic [U_BITS-1:0] i_theta,
    input  logic [2:0]        i_beta_shift,
    input  logic              i_reset_mode,
    output logic [U_BITS-1:0] o_u_next,
    output logic              o_fire
);

    localparam int V_W = U_BITS + 1;

    logic [U_BITS-1:0] w_leak;
    logic [V_W-1:0]    w_v;
    logic [U_BITS-1:0] w_v_sat;

    // Leak never exceeds u, so the subtraction cannot underflow; only the
    // add can carry into the extra bit, which then clamps to full scale.
    always_comb begin
        w_leak   = (i_beta_shift == 3'd0) ? '0 : (i_u >> i_beta_shift);
        w_v      = V_W'(i_u) - V_W'(w_leak) + V_W'(i_sum);
        w_v_sat  = w_v[U_BITS] ? '1 : w_v[U_BITS-1:0];
        o_fire   = (w_v_sat >= i_theta);
        o_u_next = w_v_sat;
        if (o_fire) begin
            o_u_next = (i_reset_mode == RST_SUB) ? (w_v_sat - i_theta) : '0;
        end
    end

endmodule

// File: rtl/lif_layer_tdm.sv
// Time-multiplexed layer of LIF neurons: one shared lif_update evaluates
// one neuron per cycle against a spike vector latched at start.
//
// state | meaning
// IDLE  | waiting for start; clear_state / weight shifting accepted
// RUN   | evaluating neuron r_idx, one per clock; done after the last one
module lif_layer_tdm
    import lif_pkg::*;
#(
    parameter int N_INPUTS  = 8,
    parameter int N_NEURONS = 16,
    parameter int U_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_INPUTS-1:0]  x_in,
    input  logic                 start,
    input  logic [U_BITS-1:0]    theta,
    input  logic [2:0]           beta_shift,
    input  logic                 reset_mode,
    input  logic                 clear_state,
    input  logic [1:0]           w_in,
    input  logic                 w_shift_en,
    output logic                 busy,
    output logic                 done,
    output logic [N_NEURONS-1:0] spikes_out
);

    localparam int SUM_W  = clog2(N_INPUTS + 1);
    localparam int IDX_W  = (N_NEURONS > 1) ? clog2(N_NEURONS) : 1;
    localparam int W_BITS = N_NEURONS * N_INPUTS;

    state_t                r_state;
    state_t                w_next_state;
    logic [IDX_W-1:0]      r_idx;
    logic [N_INPUTS-1:0]   r_x;
    logic [U_BITS-1:0]     r_theta;
    logic [2:0]            r_beta;
    logic                  r_mode;
    logic [W_BITS-1:0]     r_w;
    logic [U_BITS-1:0]     r_u [N_NEURONS];
    logic [N_NEURONS-1:0]  r_shadow;
    logic [N_NEURONS-1:0]  r_spikes;
    logic                  r_done;

    logic                  w_idle_ops;
    logic                  w_start_ok;
    logic                  w_step;
    logic                  w_last;
    logic [N_INPUTS-1:0]   w_wsel;
    logic [SUM_W-1:0]      w_sum;
    logic [U_BITS-1:0]     w_u_cur;
    logic [U_BITS-1:0]     w_u_next;
    logic                  w_fire;
    logic [N_NEURONS-1:0]  w_shadow_upd;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-cycle enables.
    always_comb begin
        w_next_state = r_state;
        w_idle_ops   = 1'b0;
        w_start_ok   = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                w_idle_ops = 1'b1;
                if (start) begin
                    w_start_ok   = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_idx == IDX_W'(N_NEURONS - 1)) begin
                    w_last       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Synaptic sum for the current neuron: weight row AND latched spikes, popcount.
    always_comb begin
        w_wsel  = r_w[r_idx*N_INPUTS +: N_INPUTS];
        w_u_cur = r_u[r_idx];
        w_sum   = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            w_sum = w_sum + SUM_W'(w_wsel[i] & r_x[i]);
        end
    end

    lif_update #(
        .U_BITS (U_BITS),
        .SUM_W  (SUM_W)
    ) u_update (
        .i_u          (w_u_cur),
        .i_sum        (w_sum),
        .i_theta      (r_theta),
        .i_beta_shift (r_beta),
        .i_reset_mode (r_mode),
        .o_u_next     (w_u_next),
        .o_fire       (w_fire)
    );

    // Shadow vector including the spike being produced this cycle, so the
    // final neuron's bit reaches spikes_out on the same edge.
    always_comb begin
        w_shadow_upd        = r_shadow;
        w_shadow_upd[r_idx] = w_fire;
    end

    // Datapath: idle housekeeping, step parameter latch, serial neuron updates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_x      <= '0;
            r_theta  <= '0;
            r_beta   <= '0;
            r_mode   <= RST_ZERO;
            r_w      <= '0;
            r_shadow <= '0;
            r_spikes <= '0;
            r_done   <= 1'b0;
            for (int k = 0; k < N_NEURONS; k++) begin
                r_u[k] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            if (w_idle_ops) begin
                if (clear_state) begin
                    for (int k = 0; k < N_NEURONS; k++) begin
                        r_u[k] <= '0;
                    end
                end
                if (w_shift_en) begin
                    r_w <= {w_in, r_w[W_BITS-1:2]};
                end
                if (w_start_ok) begin
                    r_x     <= x_in;
                    r_theta <= theta;
                    r_beta  <= beta_shift;
                    r_mode  <= reset_mode;
                    r_idx   <= '0;
                end
            end
            if (w_step) begin
                r_u[r_idx] <= w_u_next;
                r_shadow   <= w_shadow_upd;
                r_idx      <= w_last ? '0 : (r_idx + IDX_W'(1));
                if (w_last) begin
                    r_spikes <= w_shadow_upd;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign busy       = (r_state == RUN);
    assign done       = r_done;
    assign spikes_out = r_spikes;

endmodule

// File: tb/tb_lif_layer_tdm.sv
// Self-checking bench for lif_layer_tdm (8 inputs, 4 neurons, 8-bit potentials).
module tb_lif_layer_tdm;

    localparam int NI = 8;
    localparam int NN = 4;
    localparam int UB = 8;
    localparam int WB = NI * NN;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NI-1:0] x_in = '0;
    logic          start = 1'b0;
    logic [UB-1:0] theta = '0;
    logic [2:0]    beta_shift = '0;
    logic          reset_mode = 1'b0;
    logic          clear_state = 1'b0;
    logic [1:0]    w_in = '0;
    logic          w_shift_en = 1'b0;
    logic          busy;
    logic          done;
    logic [NN-1:0] spikes_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lif_layer_tdm #(
        .N_INPUTS  (NI),
        .N_NEURONS (NN),
        .U_BITS    (UB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .x_in        (x_in),
        .start       (start),
        .theta       (theta),
        .beta_shift  (beta_shift),
        .reset_mode  (reset_mode),
        .clear_state (clear_state),
        .w_in        (w_in),
        .w_shift_en  (w_shift_en),
        .busy        (busy),
        .done        (done),
        .spikes_out  (spikes_out)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a whole timestep is evaluated in one go with integer
    // arithmetic when start is accepted; outputs are released NN edges later.
    int            m_u [NN];
    logic [WB-1:0] m_w = '0;
    bit            m_busy = 1'b0;
    bit            m_done = 1'b0;
    logic [NN-1:0] m_spikes = '0;
    logic [NN-1:0] m_pend = '0;
    int            m_cnt = 0;
    bit            chk_en = 1'b0;
    int            ms, mleak, mv;
    logic [NI-1:0] mwk;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NN; k++) m_u[k] = 0;
            m_w = '0; m_busy = 0; m_done = 0; m_spikes = '0; m_cnt = 0;
        end else if (m_busy) begin
            m_done = 0;
            m_cnt--;
            if (m_cnt == 0) begin
                m_busy = 0; m_done = 1; m_spikes = m_pend;
            end
        end else begin
            m_done = 0;
            if (clear_state) for (int k = 0; k < NN; k++) m_u[k] = 0;
            if (w_shift_en) m_w = {w_in, m_w[WB-1:2]};
            if (start) begin
                for (int k = 0; k < NN; k++) begin
                    mwk   = m_w[k*NI +: NI];
                    ms    = $countones(mwk & x_in);
                    mleak = (beta_shift == 0) ? 0 : (m_u[k] >> beta_shift);
                    mv    = m_u[k] - mleak + ms;
                    if (mv > 255) mv = 255;
                    if (mv >= int'(theta)) begin
                        m_pend[k] = 1'b1;
                        m_u[k] = reset_mode ? (mv - int'(theta)) : 0;
                    end else begin
                        m_pend[k] = 1'b0;
                        m_u[k] = mv;
                    end
                end
                m_busy = 1; m_cnt = NN;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("spikes_out", spikes_out, m_spikes);
        end
    end

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_step(input logic [7:0] x, input logic [7:0] th, input logic [2:0] b,
                            input logic m, input logic clr, input logic [3:0] exp_sp,
                            input string nm);
        int lat;
        x_in = x; theta = th; beta_shift = b; reset_mode = m; clear_state = clr; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; clear_state = 1'b0;
        wait_done(lat);
        chk({nm, "_latency"}, lat, 4);
        chk({nm, "_spikes"}, spikes_out, exp_sp);
    endtask

    task automatic load_weights(input logic [31:0] wf, input logic clr_last);
        for (int j = 0; j < 16; j++) begin
            w_in = wf[2*j +: 2];
            w_shift_en = 1'b1;
            clear_state = clr_last && (j == 15);
            @(posedge clk); #1;
        end
        w_shift_en = 1'b0; clear_state = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int ndone;

        // 1: reset values, then an all-zero input step
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_spikes", spikes_out, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_step(8'h00, 8'd10, 3'd0, 1'b0, 1'b0, 4'b0000, "t1_zero_x");

        // 2: all-ones weights, reset-to-zero, theta 20: u 8,16,24(fire),8
        load_weights(32'hFFFF_FFFF, 1'b0);
        run_step(8'hFF, 8'd20, 3'd0, 1'b0, 1'b1, 4'b0000, "t2_s1");
        run_step(8'hFF, 8'd20, 3'd0, 1'b0, 1'b0, 4'b0000, "t2_s2");
        run_step(8'hFF, 8'd20, 3'd0, 1'b0, 1'b0, 4'b1111, "t2_s3");
        run_step(8'hFF, 8'd20, 3'd0, 1'b0, 1'b0, 4'b0000, "t2_s4");

        // 3: leak shift 1, subtract mode, theta 15: u 8,12,14,15(fire->0),8
        //    (start with clear in the same cycle discards the u=8 left over)
        run_step(8'hFF, 8'd15, 3'd1, 1'b1, 1'b1, 4'b0000, "t3_s1");
        run_step(8'hFF, 8'd15, 3'd1, 1'b1, 1'b0, 4'b0000, "t3_s2");
        run_step(8'hFF, 8'd15, 3'd1, 1'b1, 1'b0, 4'b0000, "t3_s3");
        run_step(8'hFF, 8'd15, 3'd1, 1'b1, 1'b0, 4'b1111, "t3_s4");
        run_step(8'hFF, 8'd15, 3'd1, 1'b1, 1'b0, 4'b0000, "t3_s5");

        // 4: saturation; clear shares a cycle with the last weight shift
        load_weights(32'hFFFF_FFFF, 1'b1);
        for (int i = 1; i <= 31; i++)
            run_step(8'hFF, 8'd255, 3'd0, 1'b0, 1'b0, 4'b0000, $sformatf("t4_s%0d", i));
        run_step(8'hFF, 8'd255, 3'd0, 1'b0, 1'b0, 4'b1111, "t4_s32");

        // 5: diagonal weights, x=0x01: only neuron 0 integrates, fires every 3rd step
        load_weights(32'h0804_0201, 1'b1);
        run_step(8'h01, 8'd3, 3'd0, 1'b0, 1'b0, 4'b0000, "t5_s1");
        run_step(8'h01, 8'd3, 3'd0, 1'b0, 1'b0, 4'b0000, "t5_s2");
        run_step(8'h01, 8'd3, 3'd0, 1'b0, 1'b0, 4'b0001, "t5_s3");
        run_step(8'h01, 8'd3, 3'd0, 1'b0, 1'b0, 4'b0000, "t5_s4");
        run_step(8'hFF, 8'd3, 3'd0, 1'b0, 1'b0, 4'b0000, "t5_s5");
        run_step(8'hFF, 8'd3, 3'd0, 1'b0, 1'b0, 4'b0001, "t5_s6");

        // 6a: start / shift / clear during RUN must be ignored
        load_weights(32'hFFFF_FFFF, 1'b1);
        x_in = 8'hFF; theta = 8'd20; beta_shift = 3'd0; reset_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; w_shift_en = 1'b1; w_in = 2'b00; clear_state = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0; w_shift_en = 1'b0; clear_state = 1'b0;
        wait_done(lat);
        chk("t6a_latency", lat, 2);
        chk("t6a_spikes", spikes_out, 4'b0000);
        run_step(8'hFF, 8'd20, 3'd0, 1'b0, 1'b0, 4'b0000, "t6a_s2");
        run_step(8'hFF, 8'd20, 3'd0, 1'b0, 1'b0, 4'b1111, "t6a_s3");

        // 6b: reset at RUN edge 2 aborts, clears u, weights and spikes_out
        x_in = 8'hFF; theta = 8'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("t6b_busy", busy, 0);
        chk("t6b_spikes", spikes_out, 4'b0000);
        ndone = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("t6b_no_done", ndone, 0);
        run_step(8'hFF, 8'd1, 3'd0, 1'b0, 1'b0, 4'b0000, "t6b_w_clear");
        load_weights(32'hFFFF_FFFF, 1'b0);
        // 6c: these run back-to-back, each start landing in the previous done cycle
        run_step(8'hFF, 8'd9, 3'd0, 1'b0, 1'b0, 4'b0000, "t6c_s1");
        run_step(8'hFF, 8'd9, 3'd0, 1'b0, 1'b0, 4'b1111, "t6c_s2");
        run_step(8'hFF, 8'd0, 3'd0, 1'b1, 1'b0, 4'b1111, "t6c_theta0");

        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
